// File: rtl/fpnew_result_reorder_buffer.sv
// In-order retirement buffer for out-of-order opgroup results: slots are allocated at issue,
// filled by slot ID as results return, and drained strictly in allocation order.
module fpnew_result_reorder_buffer #(
    parameter int Depth    = 8,
    parameter int Width    = 32,
    parameter int TagWidth = 1,
    localparam int IdWidth = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [TagWidth-1:0] alloc_tag_i,
    output logic [IdWidth-1:0]  alloc_id_o,
    input  logic                res_valid_i,
    output logic                res_ready_o,
    input  logic [IdWidth-1:0]  res_id_i,
    input  logic [Width-1:0]    res_result_i,
    input  logic [4:0]          res_status_i,
    input  logic                res_ext_bit_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    out_result_o,
    output logic [4:0]          out_status_o,
    output logic                out_ext_bit_o,
    output logic [TagWidth-1:0] out_tag_o,
    output logic                busy_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_state_e;

    slot_state_e         slot_state_q [Depth];
    logic [Width-1:0]    result_q     [Depth];
    logic [4:0]          status_q     [Depth];
    logic                ext_bit_q    [Depth];
    logic [TagWidth-1:0] tag_q        [Depth];

    logic [IdWidth:0]   head_q, head_d;
    logic [IdWidth:0]   tail_q, tail_d;
    logic               err_q, err_d;
    logic [IdWidth-1:0] head_idx, tail_idx;
    logic               full;
    logic               alloc_fire, res_hit, res_miss, retire_fire;
    logic [Depth-1:0]   slot_busy;

    assign head_idx = head_q[IdWidth-1:0];
    assign tail_idx = tail_q[IdWidth-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IdWidth] != tail_q[IdWidth]);

    // Flush squashes every event of its own cycle, including the error check.
    assign alloc_fire  = alloc_valid_i && !full && !flush_i;
    assign res_hit     = res_valid_i && (slot_state_q[res_id_i] == SLOT_PENDING) && !flush_i;
    assign res_miss    = res_valid_i && (slot_state_q[res_id_i] != SLOT_PENDING) && !flush_i;
    assign retire_fire = out_valid_o && out_ready_i && !flush_i;

    assign alloc_ready_o = !full;
    assign alloc_id_o    = tail_idx;
    assign res_ready_o   = 1'b1;
    assign out_valid_o   = (slot_state_q[head_idx] == SLOT_DONE);
    assign out_result_o  = result_q[head_idx];
    assign out_status_o  = status_q[head_idx];
    assign out_ext_bit_o = ext_bit_q[head_idx];
    assign out_tag_o     = tag_q[head_idx];
    assign busy_o        = |slot_busy;
    assign err_o         = err_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q | res_miss;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (alloc_fire)  tail_d = tail_q + 1'b1;
            if (retire_fire) head_d = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Alloc, capture and retire always address distinct slots, so priority order is immaterial.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                slot_state_q[gi] <= SLOT_FREE;
            end else if (alloc_fire && (tail_idx == IdWidth'(gi))) begin
                slot_state_q[gi] <= SLOT_PENDING;
            end else if (res_hit && (res_id_i == IdWidth'(gi))) begin
                slot_state_q[gi] <= SLOT_DONE;
            end else if (retire_fire && (head_idx == IdWidth'(gi))) begin
                slot_state_q[gi] <= SLOT_FREE;
            end
        end

        always_ff @(posedge clk_i) begin
            if (alloc_fire && (tail_idx == IdWidth'(gi))) begin
                tag_q[gi] <= alloc_tag_i;
            end
            if (res_hit && (res_id_i == IdWidth'(gi))) begin
                result_q[gi]  <= res_result_i;
                status_q[gi]  <= res_status_i;
                ext_bit_q[gi] <= res_ext_bit_i;
            end
        end

        assign slot_busy[gi] = (slot_state_q[gi] != SLOT_FREE);
    end

endmodule

// File: tb/tb_fpnew_result_reorder_buffer.sv
// Directed bench for the result reorder buffer: allocation, out-of-order capture, in-order
// retirement, full/wrap, error flag, flush and back-pressure.
module tb_fpnew_result_reorder_buffer;

    localparam int Depth    = 8;
    localparam int Width    = 32;
    localparam int TagWidth = 3;
    localparam int IdWidth  = $clog2(Depth);

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                flush_i;
    logic                alloc_valid_i;
    logic                alloc_ready_o;
    logic [TagWidth-1:0] alloc_tag_i;
    logic [IdWidth-1:0]  alloc_id_o;
    logic                res_valid_i;
    logic                res_ready_o;
    logic [IdWidth-1:0]  res_id_i;
    logic [Width-1:0]    res_result_i;
    logic [4:0]          res_status_i;
    logic                res_ext_bit_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [Width-1:0]    out_result_o;
    logic [4:0]          out_status_o;
    logic                out_ext_bit_o;
    logic [TagWidth-1:0] out_tag_o;
    logic                busy_o;
    logic                err_o;

    int n_checks = 0;
    int n_pass   = 0;

    fpnew_result_reorder_buffer #(
        .Depth    (Depth),
        .Width    (Width),
        .TagWidth (TagWidth)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_tag_i   (alloc_tag_i),
        .alloc_id_o    (alloc_id_o),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .res_id_i      (res_id_i),
        .res_result_i  (res_result_i),
        .res_status_i  (res_status_i),
        .res_ext_bit_i (res_ext_bit_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_result_o  (out_result_o),
        .out_status_o  (out_status_o),
        .out_ext_bit_o (out_ext_bit_o),
        .out_tag_o     (out_tag_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-20s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_res(input logic v, input int id, input logic [31:0] data,
                           input logic [4:0] st, input logic ext);
        res_valid_i   = v;
        res_id_i      = IdWidth'(id);
        res_result_i  = data;
        res_status_i  = st;
        res_ext_bit_i = ext;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_tag_i = '0;
        out_ready_i = 1'b0;
        set_res(1'b0, 0, 32'h0, 5'h0, 1'b0);
        tick();
        do_reset();

        // Reset state
        check("rst_alloc_ready", alloc_ready_o, 1);
        check("rst_alloc_id", alloc_id_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("res_ready", res_ready_o, 1);

        // Allocate three slots with tags 5,6,7
        for (int i = 0; i < 3; i++) begin
            alloc_valid_i = 1'b1;
            alloc_tag_i   = TagWidth'(5 + i);
            check($sformatf("alloc3_id%0d", i), alloc_id_o, i);
            tick();
        end
        alloc_valid_i = 1'b0;
        check("alloc3_busy", busy_o, 1);
        check("alloc3_out_valid", out_valid_o, 0);

        // Results return 2,0,1; retirement must follow 0,1,2
        out_ready_i = 1'b1;
        set_res(1'b1, 2, 32'h0000_00A2, 5'h01, 1'b0);
        tick();
        check("ooo_head_not_done", out_valid_o, 0);
        set_res(1'b1, 0, 32'h0000_00A0, 5'h02, 1'b1);
        tick();
        check("ooo_ret0_valid", out_valid_o, 1);
        check("ooo_ret0_tag", out_tag_o, 5);
        check("ooo_ret0_result", out_result_o, 32'hA0);
        check("ooo_ret0_ext", out_ext_bit_o, 1);
        set_res(1'b1, 1, 32'h0000_00A1, 5'h04, 1'b0);
        tick();
        set_res(1'b0, 0, 32'h0, 5'h0, 1'b0);
        check("ooo_ret1_valid", out_valid_o, 1);
        check("ooo_ret1_tag", out_tag_o, 6);
        check("ooo_ret1_result", out_result_o, 32'hA1);
        tick();
        check("ooo_ret2_valid", out_valid_o, 1);
        check("ooo_ret2_tag", out_tag_o, 7);
        check("ooo_ret2_status", out_status_o, 5'h01);
        tick();
        check("ooo_drained_valid", out_valid_o, 0);
        check("ooo_drained_busy", busy_o, 0);
        out_ready_i = 1'b0;

        // Fill all eight slots, then retire one with alloc held
        do_reset();
        for (int i = 0; i < Depth; i++) begin
            alloc_valid_i = 1'b1;
            alloc_tag_i   = TagWidth'(i);
            check($sformatf("fill_id%0d", i), alloc_id_o, i);
            tick();
        end
        check("full_alloc_ready", alloc_ready_o, 0);
        set_res(1'b1, 0, 32'hCAFE_0000, 5'h00, 1'b0);
        tick();
        set_res(1'b0, 0, 32'h0, 5'h0, 1'b0);
        out_ready_i = 1'b1;
        check("full_head_valid", out_valid_o, 1);
        check("full_ready_same_cycle", alloc_ready_o, 0);
        check("full_retire_tag", out_tag_o, 0);
        tick();
        out_ready_i = 1'b0;
        check("wrap_alloc_ready", alloc_ready_o, 1);
        check("wrap_alloc_id", alloc_id_o, 0);
        tick();
        alloc_valid_i = 1'b0;
        check("wrap_full_again", alloc_ready_o, 0);
        check("wrap_head_pending", out_valid_o, 0);

        // Result for a FREE slot raises sticky error only
        do_reset();
        set_res(1'b1, 3, 32'hDEAD_BEEF, 5'h1F, 1'b1);
        tick();
        set_res(1'b0, 0, 32'h0, 5'h0, 1'b0);
        check("err_set", err_o, 1);
        check("err_busy", busy_o, 0);
        check("err_out_valid", out_valid_o, 0);
        tick();
        tick();
        check("err_sticky", err_o, 1);

        // Four PENDING plus two DONE, then flush with alloc and result in the same cycle
        for (int i = 0; i < 6; i++) begin
            alloc_valid_i = 1'b1;
            alloc_tag_i   = TagWidth'(i);
            tick();
        end
        alloc_valid_i = 1'b0;
        set_res(1'b1, 4, 32'h44, 5'h0, 1'b0);
        tick();
        set_res(1'b1, 5, 32'h55, 5'h0, 1'b0);
        tick();
        flush_i       = 1'b1;
        alloc_valid_i = 1'b1;
        set_res(1'b1, 0, 32'h1234, 5'h0, 1'b0);
        tick();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        set_res(1'b0, 0, 32'h0, 5'h0, 1'b0);
        check("flush_busy", busy_o, 0);
        check("flush_out_valid", out_valid_o, 0);
        check("flush_alloc_id", alloc_id_o, 0);
        check("flush_alloc_ready", alloc_ready_o, 1);
        check("flush_err_kept", err_o, 1);
        alloc_valid_i = 1'b1;
        tick();
        alloc_valid_i = 1'b0;
        check("flush_no_capture", out_valid_o, 0);
        check("flush_realloc_next", alloc_id_o, 1);
        do_reset();
        check("rst_clears_err", err_o, 0);

        // Back-pressure: head DONE with out_ready low for five cycles
        alloc_valid_i = 1'b1;
        alloc_tag_i   = 3'd3;
        tick();
        alloc_valid_i = 1'b0;
        set_res(1'b1, 0, 32'h1234_5678, 5'h15, 1'b1);
        tick();
        set_res(1'b0, 0, 32'h0, 5'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), out_valid_o, 1);
            check($sformatf("hold%0d_result", i), out_result_o, 32'h1234_5678);
            check($sformatf("hold%0d_status", i), out_status_o, 5'h15);
            check($sformatf("hold%0d_tag", i), out_tag_o, 3);
            tick();
        end
        out_ready_i = 1'b1;
        check("hold_ext", out_ext_bit_o, 1);
        tick();
        out_ready_i = 1'b0;
        check("release_valid", out_valid_o, 0);
        check("release_busy", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
